// File: rtl/foc_loop_sequencer.sv
// FOC axis loop sequencer: after PLL lock, repeats encoder read -> current loop,
// with an optional decimated speed-loop stage. Also handles run/stop, a per-stage
// watchdog, an encoder-warning limit, external faults and gate-driver shutdown.
module foc_loop_sequencer #(
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int TIMEOUT_W      = 16,
    parameter int SPD_DIV_W      = 8,
    parameter int WARN_MAX       = 4,
    parameter int LOOP_CNT_W     = 16
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic                  iPll_locked,
    input  logic                  iRun,
    input  logic                  iFault_clr,
    input  logic                  iExt_fault,
    input  logic [SPD_DIV_W-1:0]  iSpd_div,
    input  logic                  iCdt_done,
    input  logic                  iCdt_warning,
    input  logic                  iCl_done,
    input  logic                  iSpd_done,
    output logic                  oCdt_en,
    output logic                  oCl_en,
    output logic                  oSpd_en,
    output logic                  oSD_n,
    output logic                  oRunning,
    output logic                  oFault,
    output logic [2:0]            oFault_code,
    output logic [LOOP_CNT_W-1:0] oLoop_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CDT_START,
        S_CDT_WAIT,
        S_CL_START,
        S_CL_WAIT,
        S_SPD_START,
        S_SPD_WAIT,
        S_FAULT
    } state_t;

    localparam int WARN_W = $clog2(WARN_MAX + 1);

    localparam logic [TIMEOUT_W-1:0]  TMO_LAST  = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0]  TMO_ONE   = TIMEOUT_W'(1);
    localparam logic [WARN_W-1:0]     WARN_LAST = WARN_W'(WARN_MAX - 1);
    localparam logic [WARN_W-1:0]     WARN_ONE  = WARN_W'(1);
    localparam logic [SPD_DIV_W-1:0]  DIV_ONE   = SPD_DIV_W'(1);
    localparam logic [LOOP_CNT_W-1:0] LOOP_ONE  = LOOP_CNT_W'(1);

    localparam logic [2:0] CODE_CDT_TMO = 3'd1;
    localparam logic [2:0] CODE_CL_TMO  = 3'd2;
    localparam logic [2:0] CODE_SPD_TMO = 3'd3;
    localparam logic [2:0] CODE_EXT     = 3'd4;
    localparam logic [2:0] CODE_PLL     = 3'd5;
    localparam logic [2:0] CODE_WARN    = 3'd6;

    state_t                state_q, state_d;
    logic [TIMEOUT_W-1:0]  tmo_q, tmo_d;
    logic [WARN_W-1:0]     warn_q, warn_d;
    logic [SPD_DIV_W-1:0]  div_q, div_d;
    logic [LOOP_CNT_W-1:0] loop_q, loop_d;
    logic [2:0]            code_q, code_d;
    // Set once a run has completed its first current-loop cycle; gates the driver
    // during the encoder stages so the first read of a run is taken with it off.
    logic                  spun_q, spun_d;
    logic                  spd_due;
    logic                  in_loop;

    logic cdt_en_q, cl_en_q, spd_en_q, sd_n_q, running_q, fault_q;

    assign in_loop = (state_q != S_IDLE) && (state_q != S_FAULT);

    // Next-state, counter and fault-code decode; external and PLL faults take priority.
    always_comb begin
        state_d = state_q;
        tmo_d   = '0;
        warn_d  = warn_q;
        div_d   = div_q;
        loop_d  = loop_q;
        code_d  = code_q;
        spun_d  = spun_q;
        spd_due = 1'b0;

        if ((state_q != S_FAULT) && iExt_fault) begin
            state_d = S_FAULT;
            code_d  = CODE_EXT;
        end else if (in_loop && !iPll_locked) begin
            state_d = S_FAULT;
            code_d  = CODE_PLL;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (iRun && iPll_locked) state_d = S_CDT_START;
                end
                S_CDT_START: state_d = S_CDT_WAIT;
                S_CDT_WAIT: begin
                    if (iCdt_done) begin
                        if (iCdt_warning && (warn_q == WARN_LAST)) begin
                            state_d = S_FAULT;
                            code_d  = CODE_WARN;
                        end else begin
                            warn_d  = iCdt_warning ? (warn_q + WARN_ONE) : '0;
                            state_d = iRun ? S_CL_START : S_IDLE;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        state_d = S_FAULT;
                        code_d  = CODE_CDT_TMO;
                    end else begin
                        tmo_d = tmo_q + TMO_ONE;
                    end
                end
                S_CL_START: state_d = S_CL_WAIT;
                S_CL_WAIT: begin
                    if (iCl_done) begin
                        loop_d = loop_q + LOOP_ONE;
                        spun_d = 1'b1;
                        // ">=" so a divider lowered below the count still fires next time.
                        if ((iSpd_div != '0) && (div_q >= (iSpd_div - DIV_ONE))) begin
                            div_d   = '0;
                            spd_due = 1'b1;
                        end else begin
                            div_d = div_q + DIV_ONE;
                        end
                        if (!iRun)        state_d = S_IDLE;
                        else if (spd_due) state_d = S_SPD_START;
                        else              state_d = S_CDT_START;
                    end else if (tmo_q == TMO_LAST) begin
                        state_d = S_FAULT;
                        code_d  = CODE_CL_TMO;
                    end else begin
                        tmo_d = tmo_q + TMO_ONE;
                    end
                end
                S_SPD_START: state_d = S_SPD_WAIT;
                S_SPD_WAIT: begin
                    if (iSpd_done) begin
                        state_d = iRun ? S_CDT_START : S_IDLE;
                    end else if (tmo_q == TMO_LAST) begin
                        state_d = S_FAULT;
                        code_d  = CODE_SPD_TMO;
                    end else begin
                        tmo_d = tmo_q + TMO_ONE;
                    end
                end
                S_FAULT: begin
                    if (iFault_clr && !iExt_fault) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        if ((state_d == S_IDLE) || (state_d == S_FAULT)) spun_d = 1'b0;
        if ((state_d == S_FAULT) && (state_q != S_FAULT)) warn_d = '0;
    end

    // State and counters, with all outputs registered from the next-state decode.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q   <= S_IDLE;
            tmo_q     <= '0;
            warn_q    <= '0;
            div_q     <= '0;
            loop_q    <= '0;
            code_q    <= '0;
            spun_q    <= 1'b0;
            cdt_en_q  <= 1'b0;
            cl_en_q   <= 1'b0;
            spd_en_q  <= 1'b0;
            sd_n_q    <= 1'b0;
            running_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            warn_q    <= warn_d;
            div_q     <= div_d;
            loop_q    <= loop_d;
            code_q    <= code_d;
            spun_q    <= spun_d;
            cdt_en_q  <= (state_d == S_CDT_START);
            cl_en_q   <= (state_d == S_CL_START);
            spd_en_q  <= (state_d == S_SPD_START);
            running_q <= (state_d != S_IDLE) && (state_d != S_FAULT);
            fault_q   <= (state_d == S_FAULT);
            sd_n_q    <= (state_d == S_CL_START) || (state_d == S_CL_WAIT) ||
                         (state_d == S_SPD_START) || (state_d == S_SPD_WAIT) ||
                         (((state_d == S_CDT_START) || (state_d == S_CDT_WAIT)) && spun_d);
        end
    end

    assign oCdt_en     = cdt_en_q;
    assign oCl_en      = cl_en_q;
    assign oSpd_en     = spd_en_q;
    assign oSD_n       = sd_n_q;
    assign oRunning    = running_q;
    assign oFault      = fault_q;
    assign oFault_code = code_q;
    assign oLoop_cnt   = loop_q;

endmodule

// File: tb/tb_foc_loop_sequencer.sv
// Directed testbench for foc_loop_sequencer with TIMEOUT_CYCLES = 50.
module tb_foc_loop_sequencer;

    logic        iClk = 1'b0;
    logic        iRst_n;
    logic        iPll_locked;
    logic        iRun;
    logic        iFault_clr;
    logic        iExt_fault;
    logic [7:0]  iSpd_div;
    logic        iCdt_done;
    logic        iCdt_warning;
    logic        iCl_done;
    logic        iSpd_done;
    logic        oCdt_en;
    logic        oCl_en;
    logic        oSpd_en;
    logic        oSD_n;
    logic        oRunning;
    logic        oFault;
    logic [2:0]  oFault_code;
    logic [15:0] oLoop_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    foc_loop_sequencer #(
        .TIMEOUT_CYCLES(50),
        .TIMEOUT_W     (16),
        .SPD_DIV_W     (8),
        .WARN_MAX      (4),
        .LOOP_CNT_W    (16)
    ) dut (
        .iClk        (iClk),
        .iRst_n      (iRst_n),
        .iPll_locked (iPll_locked),
        .iRun        (iRun),
        .iFault_clr  (iFault_clr),
        .iExt_fault  (iExt_fault),
        .iSpd_div    (iSpd_div),
        .iCdt_done   (iCdt_done),
        .iCdt_warning(iCdt_warning),
        .iCl_done    (iCl_done),
        .iSpd_done   (iSpd_done),
        .oCdt_en     (oCdt_en),
        .oCl_en      (oCl_en),
        .oSpd_en     (oSpd_en),
        .oSD_n       (oSD_n),
        .oRunning    (oRunning),
        .oFault      (oFault),
        .oFault_code (oFault_code),
        .oLoop_cnt   (oLoop_cnt)
    );

    always #5 iClk = ~iClk;

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic do_reset();
        iRst_n = 1'b0; iPll_locked = 1'b0; iRun = 1'b0; iFault_clr = 1'b0;
        iExt_fault = 1'b0; iSpd_div = 8'd3; iCdt_done = 1'b0; iCdt_warning = 1'b0;
        iCl_done = 1'b0; iSpd_done = 1'b0;
        tick(); tick();
        iRst_n = 1'b1;
        tick();
    endtask

    // Returns 1/2/3 for a CDT/CL/SPD start pulse, 9 on fault, 0 when none within the bound.
    task automatic next_pulse(output int kind);
        kind = 0;
        for (int i = 0; i < 200; i++) begin
            if (oFault)  begin kind = 9; return; end
            if (oCdt_en) begin kind = 1; return; end
            if (oCl_en)  begin kind = 2; return; end
            if (oSpd_en) begin kind = 3; return; end
            tick();
        end
    endtask

    // Answers a started stage with a one-cycle done pulse, sampled on the 10th edge.
    task automatic answer(input int kind, input bit warn);
        repeat (9) tick();
        case (kind)
            1: begin iCdt_done = 1'b1; iCdt_warning = warn; end
            2: iCl_done = 1'b1;
            3: iSpd_done = 1'b1;
            default: ;
        endcase
        tick();
        iCdt_done = 1'b0; iCdt_warning = 1'b0; iCl_done = 1'b0; iSpd_done = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if ({oCdt_en, oCl_en, oSpd_en} !== 3'b000) begin n_fail++; $display("FAIL reset_en: got %b required 000", {oCdt_en, oCl_en, oSpd_en}); end
        n_cmp++; if ({oSD_n, oRunning, oFault} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b required 000", {oSD_n, oRunning, oFault}); end
        n_cmp++; if (oFault_code !== 3'd0) begin n_fail++; $display("FAIL reset_code: got %0d required 0", oFault_code); end
        n_cmp++; if (oLoop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_loop_cnt: got %0d required 0", oLoop_cnt); end
    endtask

    task automatic test_startup();
        int exp_seq[7];
        int k;
        int n_en;
        exp_seq = '{1, 2, 1, 2, 1, 2, 3};
        do_reset();
        iRun = 1'b1;
        n_en = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (oCdt_en || oCl_en || oSpd_en) n_en++;
        end
        n_cmp++; if (n_en !== 0) begin n_fail++; $display("FAIL startup_no_lock_en: got %0d pulses required 0", n_en); end
        iPll_locked = 1'b1;
        tick();
        n_cmp++; if (oCdt_en !== 1'b1) begin n_fail++; $display("FAIL startup_cdt_en: got %b required 1", oCdt_en); end
        n_cmp++; if (oSD_n !== 1'b0) begin n_fail++; $display("FAIL startup_first_read_sd_n: got %b required 0", oSD_n); end
        for (int i = 0; i < 7; i++) begin
            next_pulse(k);
            n_cmp++; if (k !== exp_seq[i]) begin n_fail++; $display("FAIL startup_seq[%0d]: got kind %0d required %0d", i, k, exp_seq[i]); end
            if (i == 2) begin
                n_cmp++; if (oSD_n !== 1'b1) begin n_fail++; $display("FAIL startup_second_read_sd_n: got %b required 1", oSD_n); end
            end
            if (i == 6) begin
                n_cmp++; if (oLoop_cnt !== 16'd3) begin n_fail++; $display("FAIL startup_loop_cnt: got %0d required 3", oLoop_cnt); end
            end
            answer(k, 1'b0);
        end
    endtask

    task automatic test_no_speed();
        int k;
        int n_spd;
        int n_bad;
        do_reset();
        iSpd_div = 8'd0; iRun = 1'b1; iPll_locked = 1'b1;
        n_spd = 0; n_bad = 0;
        for (int i = 0; i < 20; i++) begin
            next_pulse(k);
            if (k == 3) n_spd++;
            if (k != ((i % 2 == 0) ? 1 : 2)) n_bad++;
            answer(k, 1'b0);
        end
        n_cmp++; if (n_spd !== 0) begin n_fail++; $display("FAIL nospd_spd_pulses: got %0d required 0", n_spd); end
        n_cmp++; if (n_bad !== 0) begin n_fail++; $display("FAIL nospd_sequence: got %0d bad pulses required 0", n_bad); end
        n_cmp++; if (oLoop_cnt !== 16'd10) begin n_fail++; $display("FAIL nospd_loop_cnt: got %0d required 10", oLoop_cnt); end
    endtask

    task automatic test_cl_timeout();
        int k;
        do_reset();
        iRun = 1'b1; iPll_locked = 1'b1;
        next_pulse(k); answer(k, 1'b0);
        next_pulse(k);
        n_cmp++; if (k !== 2) begin n_fail++; $display("FAIL tmo_cl_start: got kind %0d required 2", k); end
        repeat (50) tick();
        n_cmp++; if (oFault !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b required 0", oFault); end
        tick();
        n_cmp++; if (oFault !== 1'b1) begin n_fail++; $display("FAIL tmo_fault: got %b required 1", oFault); end
        n_cmp++; if (oFault_code !== 3'd2) begin n_fail++; $display("FAIL tmo_code: got %0d required 2", oFault_code); end
        n_cmp++; if (oSD_n !== 1'b0) begin n_fail++; $display("FAIL tmo_sd_n: got %b required 0", oSD_n); end
        iFault_clr = 1'b1; tick(); iFault_clr = 1'b0;
        n_cmp++; if (oFault !== 1'b0) begin n_fail++; $display("FAIL tmo_clear: got %b required 0", oFault); end
        tick();
        n_cmp++; if (oCdt_en !== 1'b1) begin n_fail++; $display("FAIL tmo_restart_cdt_en: got %b required 1", oCdt_en); end
    endtask

    task automatic test_ext_fault();
        int k;
        do_reset();
        iRun = 1'b1; iPll_locked = 1'b1;
        next_pulse(k); answer(k, 1'b0);
        next_pulse(k);
        repeat (3) tick();
        iExt_fault = 1'b1;
        tick();
        n_cmp++; if (oFault !== 1'b1) begin n_fail++; $display("FAIL ext_fault: got %b required 1", oFault); end
        n_cmp++; if (oFault_code !== 3'd4) begin n_fail++; $display("FAIL ext_code: got %0d required 4", oFault_code); end
        iFault_clr = 1'b1; tick(); iFault_clr = 1'b0; tick();
        n_cmp++; if (oFault !== 1'b1) begin n_fail++; $display("FAIL ext_clr_blocked: got %b required 1", oFault); end
        iExt_fault = 1'b0;
        iFault_clr = 1'b1; tick(); iFault_clr = 1'b0;
        n_cmp++; if (oFault !== 1'b0) begin n_fail++; $display("FAIL ext_clr: got %b required 0", oFault); end
        n_cmp++; if (oFault_code !== 3'd4) begin n_fail++; $display("FAIL ext_code_held: got %0d required 4", oFault_code); end
        next_pulse(k);
        iPll_locked = 1'b0;
        tick();
        n_cmp++; if ({oFault, oFault_code} !== {1'b1, 3'd5}) begin n_fail++; $display("FAIL pll_loss: got fault %b code %0d required 1 5", oFault, oFault_code); end
    endtask

    task automatic test_warning();
        int k;
        bit pat_b[5];
        pat_b = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        iSpd_div = 8'd0; iRun = 1'b1; iPll_locked = 1'b1;
        for (int i = 0; i < 4; i++) begin
            next_pulse(k); answer(k, 1'b1);
            if (i < 3) begin
                n_cmp++; if (oFault !== 1'b0) begin n_fail++; $display("FAIL warn_early[%0d]: got %b required 0", i, oFault); end
                next_pulse(k); answer(k, 1'b0);
            end
        end
        n_cmp++; if ({oFault, oFault_code} !== {1'b1, 3'd6}) begin n_fail++; $display("FAIL warn_limit: got fault %b code %0d required 1 6", oFault, oFault_code); end
        iFault_clr = 1'b1; tick(); iFault_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            next_pulse(k);
            n_cmp++; if (k !== 1) begin n_fail++; $display("FAIL warn_pattern_cdt[%0d]: got kind %0d required 1", i, k); end
            answer(k, pat_b[i]);
            next_pulse(k); answer(k, 1'b0);
        end
        n_cmp++; if ({oFault, oRunning} !== 2'b01) begin n_fail++; $display("FAIL warn_pattern: got fault/running %b required 01", {oFault, oRunning}); end
    endtask

    task automatic test_run_stop();
        int k;
        int n_en;
        do_reset();
        iRun = 1'b1; iPll_locked = 1'b1;
        next_pulse(k); answer(k, 1'b0);
        next_pulse(k);
        repeat (4) tick();
        iRun = 1'b0;
        repeat (4) tick();
        iCl_done = 1'b1; tick(); iCl_done = 1'b0;
        n_cmp++; if (oLoop_cnt !== 16'd1) begin n_fail++; $display("FAIL stop_cl_accepted: got %0d required 1", oLoop_cnt); end
        n_cmp++; if ({oRunning, oSD_n} !== 2'b00) begin n_fail++; $display("FAIL stop_idle: got running/sd_n %b required 00", {oRunning, oSD_n}); end
        n_en = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 5) iCdt_done = 1'b1;
            if (i == 6) iCdt_done = 1'b0;
            tick();
            if (oCdt_en || oCl_en || oSpd_en) n_en++;
        end
        n_cmp++; if (n_en !== 0) begin n_fail++; $display("FAIL stop_no_en: got %0d pulses required 0", n_en); end
    endtask

    task automatic test_same_cycle();
        int k;
        do_reset();
        iRun = 1'b1; iPll_locked = 1'b1;
        next_pulse(k); answer(k, 1'b0);
        next_pulse(k);
        repeat (50) tick();
        iCl_done = 1'b1; tick(); iCl_done = 1'b0;
        n_cmp++; if ({oFault, oCdt_en} !== 2'b01) begin n_fail++; $display("FAIL same_cycle_cl: got fault/cdt_en %b required 01", {oFault, oCdt_en}); end
        repeat (50) tick();
        iCdt_done = 1'b1; tick(); iCdt_done = 1'b0;
        n_cmp++; if ({oFault, oCl_en} !== 2'b01) begin n_fail++; $display("FAIL same_cycle_cdt: got fault/cl_en %b required 01", {oFault, oCl_en}); end
    endtask

    task automatic test_async_reset();
        int k;
        do_reset();
        iRun = 1'b1; iPll_locked = 1'b1;
        next_pulse(k);
        repeat (51) tick();
        n_cmp++; if ({oFault, oFault_code} !== {1'b1, 3'd1}) begin n_fail++; $display("FAIL cdt_timeout: got fault %b code %0d required 1 1", oFault, oFault_code); end
        #3;
        iRst_n = 1'b0;
        #1;
        n_cmp++; if ({oFault, oFault_code, oRunning} !== 5'b0) begin n_fail++; $display("FAIL async_reset: got fault %b code %0d running %b required all 0", oFault, oFault_code, oRunning); end
        tick();
        iRst_n = 1'b1;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_startup();
        test_no_speed();
        test_cl_timeout();
        test_ext_fault();
        test_warning();
        test_run_stop();
        test_same_cycle();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
